// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the frame sequencer and the unit modules that decode
// its sub-state buses.
//   phase_e  : top-level phase of the sequencer.
//   M_*/C_*/D_* : codes driven on the MS, CS and DS buses.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_MEM  = 3'd1,
    PH_COMP = 3'd2,
    PH_DISP = 3'd3,
    PH_HALT = 3'd4
  } phase_e;

  localparam logic [2:0] M_IDLE  = 3'd0;
  localparam logic [2:0] M_ADDR  = 3'd1;
  localparam logic [2:0] M_READ  = 3'd2;
  localparam logic [2:0] M_DONE  = 3'd3;

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_LOAD  = 3'd1;
  localparam logic [2:0] C_EXEC  = 3'd2;
  localparam logic [2:0] C_STORE = 3'd3;
  localparam logic [2:0] C_DONE  = 3'd4;

  localparam logic [2:0] D_IDLE  = 3'd0;
  localparam logic [2:0] D_LATCH = 3'd1;
  localparam logic [2:0] D_SHOW  = 3'd2;
  localparam logic [2:0] D_DONE  = 3'd3;

endpackage

// File: rtl/seq_step_counter.sv
// Loadable 8-bit down-counter with terminal-count flag.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous reset, active-low
//   load     : load load_val (takes priority over dec)
//   load_val : value loaded; it is the number of remaining decrements
//   dec      : decrement by one, saturating at zero
//   tc       : high while the count is zero
module seq_step_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       tc
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Saturating at zero keeps the counter from wrapping if a caller
  // decrements once too often.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == 8'd0);

endmodule

// File: rtl/seq_controller.sv
// Frame sequencer: drives Memory -> Computation -> Display phases through the
// MS, CS and DS sub-state buses, looping forever (LOOP=1) or halting after
// one frame (LOOP=0).
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous reset, active-low
//   pause      : hold everything while high (only with SEQ_CTRL_PAUSE_EN)
//   MS/CS/DS   : memory / computation / display sub-state codes
//   busy       : high in MEM, COMP and DISP phases
//   frame_done : one-cycle pulse during D_DONE
//   halted     : high in HALT
// Optional feature macro: SEQ_CTRL_PAUSE_EN adds the pause input.
module seq_controller
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned N_WORDS     = 4,
  parameter int unsigned COMP_CYCLES = 3,
  parameter int unsigned DISP_CYCLES = 2,
  parameter int unsigned LOOP        = 1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SEQ_CTRL_PAUSE_EN
  input  logic       pause,
`endif
  output logic [2:0] MS,
  output logic [2:0] CS,
  output logic [2:0] DS,
  output logic       busy,
  output logic       frame_done,
  output logic       halted
);

  if (N_WORDS < 1 || N_WORDS > 255) begin : g_bad_n_words
    $error("seq_controller: N_WORDS must be 1..255");
  end
  if (COMP_CYCLES < 1 || COMP_CYCLES > 255) begin : g_bad_comp_cycles
    $error("seq_controller: COMP_CYCLES must be 1..255");
  end
  if (DISP_CYCLES < 1 || DISP_CYCLES > 255) begin : g_bad_disp_cycles
    $error("seq_controller: DISP_CYCLES must be 1..255");
  end
  if (LOOP > 1) begin : g_bad_loop
    $error("seq_controller: LOOP must be 0 or 1");
  end

  // Counters hold the number of repeats still to go after the current one,
  // so terminal count marks the last word / last cycle of a sub-state.
  localparam logic [7:0] WORDS_M1 = 8'(N_WORDS - 1);
  localparam logic [7:0] EXEC_M1  = 8'(COMP_CYCLES - 1);
  localparam logic [7:0] SHOW_M1  = 8'(DISP_CYCLES - 1);

  phase_e     phase_q, phase_d;
  logic [2:0] ms_q, ms_d, cs_q, cs_d, ds_q, ds_d;
  logic       busy_q, busy_d, frame_done_q, frame_done_d, halted_q, halted_d;
  logic       word_load, word_dec, word_tc;
  logic       step_load, step_dec, step_tc;
  logic [7:0] step_load_val;
  logic       hold;

`ifdef SEQ_CTRL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  seq_step_counter u_word_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (word_load),
    .load_val (WORDS_M1),
    .dec      (word_dec),
    .tc       (word_tc)
  );

  seq_step_counter u_step_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (step_load),
    .load_val (step_load_val),
    .dec      (step_dec),
    .tc       (step_tc)
  );

  // Next-state logic. Each *_DONE code hands straight over to the next
  // unit's first code on the following edge. A D_DONE cycle reached with
  // frame_done low means the pulse was suppressed by pause, so D_DONE is
  // repeated once with the pulse before moving on.
  always_comb begin
    phase_d       = phase_q;
    ms_d          = ms_q;
    cs_d          = cs_q;
    ds_d          = ds_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    halted_d      = halted_q;
    word_load     = 1'b0;
    word_dec      = 1'b0;
    step_load     = 1'b0;
    step_dec      = 1'b0;
    step_load_val = 8'd0;
    if (!hold) begin
      unique case (phase_q)
        PH_IDLE: begin
          phase_d   = PH_MEM;
          ms_d      = M_ADDR;
          busy_d    = 1'b1;
          word_load = 1'b1;
        end
        PH_MEM: begin
          case (ms_q)
            M_ADDR: ms_d = M_READ;
            M_READ: begin
              if (word_tc) begin
                ms_d = M_DONE;
              end else begin
                ms_d     = M_ADDR;
                word_dec = 1'b1;
              end
            end
            default: begin
              ms_d    = M_IDLE;
              phase_d = PH_COMP;
              cs_d    = C_LOAD;
            end
          endcase
        end
        PH_COMP: begin
          case (cs_q)
            C_LOAD: begin
              cs_d          = C_EXEC;
              step_load     = 1'b1;
              step_load_val = EXEC_M1;
            end
            C_EXEC: begin
              if (step_tc) begin
                cs_d = C_STORE;
              end else begin
                step_dec = 1'b1;
              end
            end
            C_STORE: cs_d = C_DONE;
            default: begin
              cs_d    = C_IDLE;
              phase_d = PH_DISP;
              ds_d    = D_LATCH;
            end
          endcase
        end
        PH_DISP: begin
          case (ds_q)
            D_LATCH: begin
              ds_d          = D_SHOW;
              step_load     = 1'b1;
              step_load_val = SHOW_M1;
            end
            D_SHOW: begin
              if (step_tc) begin
                ds_d         = D_DONE;
                frame_done_d = 1'b1;
              end else begin
                step_dec = 1'b1;
              end
            end
            default: begin
              if (!frame_done_q) begin
                frame_done_d = 1'b1;
              end else begin
                ds_d = D_IDLE;
                if (LOOP != 0) begin
                  phase_d   = PH_MEM;
                  ms_d      = M_ADDR;
                  word_load = 1'b1;
                end else begin
                  phase_d  = PH_HALT;
                  busy_d   = 1'b0;
                  halted_d = 1'b1;
                end
              end
            end
          endcase
        end
        default: begin
          phase_d = PH_HALT;
        end
      endcase
    end
  end

  // State register; reset aborts any frame in flight without a pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q      <= PH_IDLE;
      ms_q         <= M_IDLE;
      cs_q         <= C_IDLE;
      ds_q         <= D_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      ms_q         <= ms_d;
      cs_q         <= cs_d;
      ds_q         <= ds_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      halted_q     <= halted_d;
    end
  end

  assign MS         = ms_q;
  assign CS         = cs_q;
  assign DS         = ds_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: three instances (defaults, LOOP=0, and
// all-minimum parameters) share clock and reset. Expected codes come from a
// position-in-frame model written from the phase timing description.
module tb_seq_controller;

  logic clk = 1'b0;
  logic rst;
`ifdef SEQ_CTRL_PAUSE_EN
  logic pause;
`endif

  logic [2:0] msA, csA, dsA, msH, csH, dsH, msM, csM, dsM;
  logic       busyA, fdA, haltA, busyH, fdH, haltH, busyM, fdM, haltM;

  int checkCount = 0;
  int passCount  = 0;
  int fdCount    = 0;

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  seq_controller dutDefault (
    .clk(clk), .rst(rst),
`ifdef SEQ_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .MS(msA), .CS(csA), .DS(dsA), .busy(busyA), .frame_done(fdA), .halted(haltA)
  );

  seq_controller #(.LOOP(0)) dutHalt (
    .clk(clk), .rst(rst),
`ifdef SEQ_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .MS(msH), .CS(csH), .DS(dsH), .busy(busyH), .frame_done(fdH), .halted(haltH)
  );

  seq_controller #(.N_WORDS(1), .COMP_CYCLES(1), .DISP_CYCLES(1)) dutMin (
    .clk(clk), .rst(rst),
`ifdef SEQ_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .MS(msM), .CS(csM), .DS(dsM), .busy(busyM), .frame_done(fdM), .halted(haltM)
  );

  // Expected {MS,CS,DS,busy,frame_done,halted} at position p (1-based) of a frame
  function automatic logic [11:0] frameExp(input int p, input int nw, input int cc, input int dc);
    logic [2:0] ms, cs, ds;
    logic       fd;
    int         q, r;
    ms = 3'd0; cs = 3'd0; ds = 3'd0; fd = 1'b0;
    q = p - (2 * nw + 1);
    r = q - (cc + 3);
    if (p <= 2 * nw)        ms = (p % 2 == 1) ? 3'd1 : 3'd2;
    else if (q == 0)        ms = 3'd3;
    else if (q == 1)        cs = 3'd1;
    else if (q <= cc + 1)   cs = 3'd2;
    else if (q == cc + 2)   cs = 3'd3;
    else if (q == cc + 3)   cs = 3'd4;
    else if (r == 1)        ds = 3'd1;
    else if (r <= dc + 1)   ds = 3'd2;
    else begin
      ds = 3'd3;
      fd = 1'b1;
    end
    return {ms, cs, ds, 1'b1, fd, 1'b0};
  endfunction

  // Expected outputs at edge e after reset release for a looping instance
  function automatic logic [11:0] loopExp(input int e, input int nw, input int cc, input int dc);
    int period;
    period = 2 * nw + cc + dc + 6;
    return frameExp((e - 1) % period + 1, nw, cc, dc);
  endfunction

  // Drive reset for one edge and sample 1 unit after the edge
  task automatic applyStimulus(input logic rstVal);
    rst = rstVal;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obsA();
    return {msA, csA, dsA, busyA, fdA, haltA};
  endfunction
  function automatic logic [11:0] obsH();
    return {msH, csH, dsH, busyH, fdH, haltH};
  endfunction
  function automatic logic [11:0] obsM();
    return {msM, csM, dsM, busyM, fdM, haltM};
  endfunction

  initial begin
    int nonZero;
`ifdef SEQ_CTRL_PAUSE_EN
    pause = 1'b0;
`endif
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 5; i++) applyStimulus(1'b0);
    checkOutput("resetDefault", 32'(obsA()), 32'd0);
    checkOutput("resetHalt", 32'(obsH()), 32'd0);
    checkOutput("resetMin", 32'(obsM()), 32'd0);

    // Free run: looping, halting and minimum-parameter instances together
    for (int e = 1; e <= 100; e++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("default e%0d", e), 32'(obsA()), 32'(loopExp(e, 4, 3, 2)));
      checkOutput($sformatf("halt e%0d", e), 32'(obsH()),
                  (e <= 19) ? 32'(frameExp(e, 4, 3, 2)) : 32'h001);
      checkOutput($sformatf("min e%0d", e), 32'(obsM()), 32'(loopExp(e, 1, 1, 1)));
      nonZero = int'(msA != 3'd0) + int'(csA != 3'd0) + int'(dsA != 3'd0);
      checkOutput($sformatf("mutex e%0d", e), 32'(nonZero <= 1), 32'd1);
      if (fdA) fdCount++;
    end
    checkOutput("frameDoneCount", 32'(fdCount), 32'd5);

    // Reset in the middle of C_EXEC aborts the frame
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    for (int e = 1; e <= 11; e++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("preAbort e%0d", e), 32'(obsA()), 32'(loopExp(e, 4, 3, 2)));
    end
    applyStimulus(1'b0);
    checkOutput("midReset", 32'(obsA()), 32'd0);
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("restart e%0d", e), 32'(obsA()), 32'(loopExp(e, 4, 3, 2)));
    end

`ifdef SEQ_CTRL_PAUSE_EN
    // Pause for three edges while CS=C_EXEC; everything shifts by three
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    for (int e = 1; e <= 11; e++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("prePause e%0d", e), 32'(obsA()), 32'(loopExp(e, 4, 3, 2)));
    end
    pause = 1'b1;
    for (int e = 12; e <= 14; e++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("paused e%0d", e), 32'(obsA()), 32'(loopExp(11, 4, 3, 2)));
    end
    pause = 1'b0;
    for (int e = 15; e <= 25; e++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("resumed e%0d", e), 32'(obsA()), 32'(loopExp(e - 3, 4, 3, 2)));
    end
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
